idct_pass_sched: RTL and testbench
==================================

Name: idct_pass_sched

Overview:
- Sequences one 8x8 inverse DCT: eight row operations, then eight column operations, each issued to a shared row/column compute unit as a start index into the 64-entry coefficient block.
- Sits between the top-level block buffer control and the Fast_IDCT datapath.
- Replaces the hard-wired per-instance start indices with a time-multiplexed, handshaked schedule.
- Allows a bounded number of operations in flight and enforces a full row-pass drain before the column pass begins.

Parameters:
- N, 8, block dimension; operations per pass, N*N block entries.
- IDXW, 6, start-index width; must equal clog2(N*N).
- MAX_OUT, 2, maximum operations issued but not yet completed (1..4).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request one full 2-D transform; sampled in IDLE only.
- busy  out  1  high from the cycle after an accepted start through the cycle done is asserted.
- done  out  1  one-cycle pulse when the last column operation completes.
- op_valid  out  1  operation request to the compute unit.
- op_ready  in  1  compute unit accepts the request this cycle.
- op_is_col  out  1  0 = row operation, 1 = column operation.
- op_index  out  IDXW  start index: row r -> r*N; column c -> c.
- op_done  in  1  compute unit finished one operation (one pulse per operation).
- err  out  1  sticky: op_done arrived with nothing outstanding.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, op_valid=0, op_is_col=0, op_index=0, err=0; issue counter=0, outstanding counter=0.
- Reset mid-transform abandons the operation; in-flight op_done pulses after release are counted as errors.
- States: IDLE, ROW, ROW_DRAIN, COL, COL_DRAIN, FIN.
- IDLE: start=1 -> ROW; issue counter cleared. start in any other state is ignored (no queuing).
- ROW: op_valid=1 when outstanding < MAX_OUT.
  - op_is_col=0, op_index=issue*N.
  - On op_valid&&op_ready: issue++, outstanding++.
  - After issue N-1 is accepted -> ROW_DRAIN.
- ROW_DRAIN: op_valid=0; when outstanding==0 (including the cycle it reaches 0 by op_done) -> COL next cycle with issue cleared.
- COL: same as ROW with op_is_col=1, op_index=issue. After issue N-1 is accepted -> COL_DRAIN.
- COL_DRAIN: as ROW_DRAIN; when outstanding reaches 0 -> FIN.
- FIN: done=1 for exactly one cycle, busy=1 that cycle; next state IDLE, busy=0.
- Minimum latency, with op_ready=1 and op_done returned one cycle after accept, MAX_OUT>=2: start at cycle 0 -> first op_valid at cycle 1 -> done at cycle 2N+4.
- Handshake:
  - Once op_valid is asserted, op_valid, op_is_col and op_index hold stable until op_ready.
  - op_valid is never retracted.
  - op_ready while op_valid=0 has no effect.
- Accept and op_done in the same cycle: outstanding is unchanged.
- Outstanding never exceeds MAX_OUT. At MAX_OUT, op_valid drops the cycle after the accept that filled it and rises the cycle after an op_done frees a slot.
- op_done with outstanding==0 (and no accept that cycle): outstanding stays 0, err set. err clears only on reset.
- Index arithmetic is unsigned, computed at width IDXW; the maximum value N*N-1 cannot wrap.
- outstanding counter width is clog2(MAX_OUT+1).

Optional Feature:
- Macro: IDCT_SCHED_PERF_EN.
- Defined: adds output port cycles [15:0].
  - Cleared on an accepted start.
  - Increments every cycle while busy=1, saturating at 16'hFFFF.
  - Holds its value in IDLE.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Ideal unit (op_ready=1, op_done one cycle after accept), start pulse at cycle 0:
  - op_index sequence 0,8,...,56 (op_is_col=0), then 0,1,...,7 (op_is_col=1).
  - done single pulse at cycle 20; busy low at cycle 21.
- MAX_OUT=2, op_ready=1, op_done withheld:
  - Exactly 2 issues (indices 0, 8), then op_valid=0.
  - One op_done -> index 16 issued next cycle.
  - No column operation until all 8 row op_done pulses are received.
- op_ready low for 5 cycles on row 3: op_valid stays 1 with op_index=24 stable for 5 cycles; issue 24 happens once.
- start pulsed during COL: ignored; exactly 16 operations and one done pulse.
- op_done while idle: err=1 and stays 1 across a following full transform; outstanding unaffected.
- reset low during row 5 (asynchronous, mid-cycle):
  - All outputs 0 immediately.
  - After release, a new start produces the full 16-operation sequence from index 0.

Source files
------------

// File: rtl/idct_pass_sched.sv
// Row/column pass scheduler for one 8x8 IDCT: issues N row ops then N column ops
// to a shared compute unit with bounded in-flight count. Optional macro: IDCT_SCHED_PERF_EN.
module idct_pass_sched #(
  parameter int N       = 8,
  parameter int IDXW    = 6,
  parameter int MAX_OUT = 2
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_op_valid,
  input  logic            i_op_ready,
  output logic            o_op_is_col,
  output logic [IDXW-1:0] o_op_index,
  input  logic            i_op_done,
  output logic            o_err
`ifdef IDCT_SCHED_PERF_EN
  ,
  output logic [15:0]     o_cycles
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_ROW_DRAIN,
    S_COL,
    S_COL_DRAIN,
    S_FIN
  } state_t;

  state_t          r_state, w_nxt;
  logic [CW-1:0]   r_issue;
  logic [OW-1:0]   r_out, w_out_nxt;
  logic            r_err;
  logic            w_issuing, w_op_valid, w_accept, w_last, w_err_set;

  assign w_issuing  = (r_state == S_ROW) || (r_state == S_COL);
  assign w_op_valid = w_issuing && (r_out < OW'(MAX_OUT));
  assign w_accept   = w_op_valid && i_op_ready;
  assign w_last     = (r_issue == CW'(N - 1));
  assign w_err_set  = i_op_done && !w_accept && (r_out == '0);

  // Accept and completion in the same cycle cancel out.
  always_comb begin
    w_out_nxt = r_out;
    if (w_accept && !i_op_done)
      w_out_nxt = r_out + OW'(1);
    else if (!w_accept && i_op_done && (r_out != '0))
      w_out_nxt = r_out - OW'(1);
  end

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_nxt;
  end

  // Row drain hands over on the completing cycle; column drain waits for the
  // counter to settle at zero, giving done at 2N+4 on an ideal unit.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:      if (i_start) w_nxt = S_ROW;
      S_ROW:       if (w_accept && w_last) w_nxt = S_ROW_DRAIN;
      S_ROW_DRAIN: if (w_out_nxt == '0) w_nxt = S_COL;
      S_COL:       if (w_accept && w_last) w_nxt = S_COL_DRAIN;
      S_COL_DRAIN: if (r_out == '0) w_nxt = S_FIN;
      S_FIN:       w_nxt = S_IDLE;
      default:     w_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_FIN);
    o_op_valid  = w_op_valid;
    o_op_is_col = (r_state == S_COL);
    o_op_index  = '0;
    if (r_state == S_ROW)      o_op_index = IDXW'(r_issue) * IDXW'(N);
    else if (r_state == S_COL) o_op_index = IDXW'(r_issue);
    o_err       = r_err;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_issue <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || (r_state == S_ROW_DRAIN)) r_issue <= '0;
      else if (w_accept)                                   r_issue <= r_issue + CW'(1);
      r_out <= w_out_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

`ifdef IDCT_SCHED_PERF_EN
  logic [15:0] r_cycles;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)                            r_cycles <= '0;
    else if ((r_state == S_IDLE) && i_start)   r_cycles <= '0;
    else if (o_busy && (r_cycles != 16'hFFFF)) r_cycles <= r_cycles + 16'd1;
  end
  assign o_cycles = r_cycles;
`endif

endmodule

// File: tb/tb_idct_pass_sched.sv
// Self-checking bench for idct_pass_sched: scenario tasks against a queue-based
// model of the compute unit and the expected 16-operation order.
module tb_idct_pass_sched;
  localparam int N       = 8;
  localparam int MAX_OUT = 2;
  localparam int BUDGET  = 400;

  logic       clk = 1'b0;
  logic       rst_n, start, op_ready, op_done;
  logic       busy, done, op_valid, op_is_col, err;
  logic [5:0] op_index;
`ifdef IDCT_SCHED_PERF_EN
  logic [15:0] cycles;
`endif

  int total = 0;
  int bad   = 0;
  bit err_exp = 1'b0;

  idct_pass_sched #(.N(N), .IDXW(6), .MAX_OUT(MAX_OUT)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start),
    .o_busy(busy), .o_done(done), .o_op_valid(op_valid), .i_op_ready(op_ready),
    .o_op_is_col(op_is_col), .o_op_index(op_index), .i_op_done(op_done),
    .o_err(err)
`ifdef IDCT_SCHED_PERF_EN
    , .o_cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k-th operation of a transform: rows at k*N, then columns at k-N
  function automatic logic [6:0] exp_op(input int k);
    logic [6:0] r;
    if (k < N) r = {1'b0, 6'(k * N)};
    else       r = {1'b1, 6'(k - N)};
    return r;
  endfunction

  // Full transform with a modelled compute unit: random ready, in-order
  // completions with random latency, optional stall and mid-column start.
  task automatic run_xform(input int rdy_pct, input int max_lat, input int stall_idx,
                           input int stall_len, input bit start_mid,
                           output int n_acc, output int done_cyc, output int stall_seen);
    int    mout, n_cmpl, last_due, d;
    int    due[$];
    bit    pv, pr, rdy, dn, mid_sent;
    logic  pc;
    logic [5:0] pi;
    n_acc = 0; done_cyc = -1; stall_seen = 0;
    mout = 0; n_cmpl = 0; last_due = 0; pv = 0; pr = 0; pc = 0; pi = 0; mid_sent = 0;
    tick();
    start = 1'b1; op_ready = 1'b0; op_done = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      tick();
      start = 1'b0;
      if (done_cyc >= 0) begin
        total++;
        if ({busy, done} !== 2'b00) begin
          bad++;
          $display("FAIL after_done cyc=%0d busy/done=%b want 00", cyc, {busy, done});
        end
        break;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        total++;
        if (busy !== 1'b1 || n_cmpl != 2 * N) begin
          bad++;
          $display("FAIL done_pulse cyc=%0d busy=%b completions=%0d want busy=1 completions=%0d",
                   cyc, busy, n_cmpl, 2 * N);
        end
      end
      if (pv && !pr) begin
        total++;
        if ({op_valid, op_is_col, op_index} !== {1'b1, pc, pi}) begin
          bad++;
          $display("FAIL hold cyc=%0d got v=%b c=%b i=%0d want v=1 c=%b i=%0d",
                   cyc, op_valid, op_is_col, op_index, pc, pi);
        end
      end
      if (op_valid === 1'b1) begin
        total++;
        if (n_acc >= 2 * N || {op_is_col, op_index} !== exp_op(n_acc)) begin
          bad++;
          $display("FAIL op_order k=%0d got c=%b i=%0d want %h", n_acc, op_is_col, op_index,
                   (n_acc < 2 * N) ? exp_op(n_acc) : 7'h7f);
        end
        total++;
        if (mout >= MAX_OUT || (op_is_col === 1'b1 && n_cmpl < N)) begin
          bad++;
          $display("FAIL op_gate cyc=%0d outstanding=%0d row_done=%0d col=%b",
                   cyc, mout, n_cmpl, op_is_col);
        end
      end
      if (op_valid === 1'b1 && op_is_col === 1'b0 && op_index == 6'(stall_idx) &&
          stall_seen < stall_len) begin
        rdy = 1'b0;
        stall_seen++;
      end else begin
        rdy = ($urandom % 100) < rdy_pct;
      end
      if (start_mid && !mid_sent && op_valid === 1'b1 && op_is_col === 1'b1) begin
        start = 1'b1;
        mid_sent = 1'b1;
      end
      dn = (due.size() > 0) && (due[0] <= cyc);
      if (dn) begin
        void'(due.pop_front());
        mout--;
        n_cmpl++;
      end
      if (op_valid === 1'b1 && rdy) begin
        n_acc++;
        mout++;
        d = cyc + 1 + $urandom_range(0, max_lat);
        if (d <= last_due) d = last_due + 1;
        due.push_back(d);
        last_due = d;
      end
      pv = (op_valid === 1'b1); pr = rdy; pc = op_is_col; pi = op_index;
      op_ready = rdy;
      op_done = dn;
    end
    op_ready = 1'b0; op_done = 1'b0; start = 1'b0;
    total++;
    if (done_cyc < 0 || n_acc != 2 * N) begin
      bad++;
      $display("FAIL xform_end done_cyc=%0d ops=%0d want done and %0d ops", done_cyc, n_acc, 2 * N);
    end
    total++;
    if (err !== err_exp) begin
      bad++;
      $display("FAIL err_flag got %b want %b", err, err_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_ready = 1'b0; op_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, op_valid, op_is_col, op_index, err} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got %b want 0", {busy, done, op_valid, op_is_col, op_index, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    total++;
    if ({busy, done, op_valid, err} !== 4'd0) begin
      bad++;
      $display("FAIL idle_after_reset got %b want 0", {busy, done, op_valid, err});
    end
  endtask

  task automatic test_ideal();
    int n_acc, dcyc, st;
    run_xform(100, 0, -1, 0, 1'b0, n_acc, dcyc, st);
    total++;
    if (dcyc != 2 * N + 4) begin
      bad++;
      $display("FAIL ideal_latency done at %0d want %0d", dcyc, 2 * N + 4);
    end
`ifdef IDCT_SCHED_PERF_EN
    total++;
    if (cycles !== 16'd20) begin
      bad++;
      $display("FAIL perf_cycles got %0d want 20", cycles);
    end
`endif
  endtask

  task automatic test_backpressure();
    int acc_idx[$];
    int mout, n_cmpl, n_acc, col_early;
    bit seen_done;
    tick();
    start = 1'b1; op_ready = 1'b1; op_done = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      start = 1'b0;
      if (op_valid === 1'b1) acc_idx.push_back(int'(op_index));
    end
    total++;
    if (acc_idx.size() != 2 || acc_idx[0] != 0 || acc_idx[1] != 8 || op_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_fill issued=%0d valid=%b want 2 issues (0,8) valid=0", acc_idx.size(), op_valid);
    end
    tick();
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    total++;
    if (op_valid !== 1'b1 || op_index !== 6'd16 || op_is_col !== 1'b0) begin
      bad++;
      $display("FAIL bp_refill got v=%b i=%0d want v=1 i=16", op_valid, op_index);
    end
    mout = 2; n_cmpl = 1; n_acc = 3; col_early = 0; seen_done = 0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (cyc > 0) tick();
      if (done === 1'b1) begin
        seen_done = 1;
        break;
      end
      if (op_valid === 1'b1 && op_is_col === 1'b1 && n_cmpl < N) col_early++;
      op_done = (mout > 0) && (cyc % 3 == 2);
      if (op_done) begin mout--; n_cmpl++; end
      if (op_valid === 1'b1 && cyc > 0) begin n_acc++; mout++; end
      else if (op_valid === 1'b1) mout++;
    end
    op_done = 1'b0; op_ready = 1'b0;
    total++;
    if (col_early != 0 || !seen_done || n_acc != 2 * N) begin
      bad++;
      $display("FAIL bp_drain early_cols=%0d done=%0d ops=%0d want 0,1,%0d", col_early, seen_done, n_acc, 2 * N);
    end
    tick();
  endtask

  task automatic test_stall();
    int n_acc, dcyc, st;
    run_xform(100, 0, 24, 5, 1'b0, n_acc, dcyc, st);
    total++;
    if (st != 5 || dcyc != 2 * N + 4 + 5) begin
      bad++;
      $display("FAIL stall stall_cycles=%0d done=%0d want 5 and %0d", st, dcyc, 2 * N + 9);
    end
  endtask

  task automatic test_start_in_col();
    int n_acc, dcyc, st;
    run_xform(80, 2, -1, 0, 1'b1, n_acc, dcyc, st);
    repeat (3) tick();
    total++;
    if ({busy, op_valid, done} !== 3'b000) begin
      bad++;
      $display("FAIL start_ignored got busy/valid/done=%b want 000", {busy, op_valid, done});
    end
  endtask

  task automatic test_random();
    int n_acc, dcyc, st;
    for (int r = 0; r < 4; r++) begin
      run_xform(30 + 20 * r, 5 - r, -1, 0, 1'b0, n_acc, dcyc, st);
      tick();
    end
  endtask

  task automatic test_err_idle();
    int n_acc, dcyc, st;
    tick();
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    err_exp = 1'b1;
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL err_idle got err=%b busy=%b want err=1 busy=0", err, busy);
    end
    run_xform(100, 0, -1, 0, 1'b0, n_acc, dcyc, st);
    total++;
    if (dcyc != 2 * N + 4) begin
      bad++;
      $display("FAIL err_no_effect done at %0d want %0d", dcyc, 2 * N + 4);
    end
  endtask

  task automatic test_reset_mid();
    int n_acc, dcyc, st;
    bit prev_acc, hit;
    tick();
    start = 1'b1; op_ready = 1'b1; op_done = 1'b0; prev_acc = 0; hit = 0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      tick();
      start = 1'b0;
      op_done = prev_acc;
      prev_acc = (op_valid === 1'b1);
      if (op_valid === 1'b1 && op_is_col === 1'b0 && op_index == 6'd40) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reach_row5 not seen within 40 cycles");
    end
    #2;
    rst_n = 1'b0;
    #1;
    err_exp = 1'b0;
    total++;
    if ({busy, done, op_valid, op_is_col, op_index, err} !== 11'd0) begin
      bad++;
      $display("FAIL async_reset got %b want 0", {busy, done, op_valid, op_is_col, op_index, err});
    end
    op_done = 1'b0; op_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    err_exp = 1'b1;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL stale_done_err got %b want 1", err);
    end
    run_xform(100, 0, -1, 0, 1'b0, n_acc, dcyc, st);
    total++;
    if (dcyc != 2 * N + 4) begin
      bad++;
      $display("FAIL post_reset_latency done at %0d want %0d", dcyc, 2 * N + 4);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_backpressure();
    test_stall();
    test_start_in_col();
    test_random();
    test_err_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
